// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
//   Multi-digit packed-BCD subtractor: diff = a - b - bin, one digit per
//   clock, least significant digit first. Companion to the single-digit BCD
//   adder so the datapath can do A-B on the same packed-BCD operand format.
//   A start/busy/done handshake frames each operation; the result, borrow
//   and invalid flag are held until the next accepted start.
//
// Parameters
//   DIGITS   number of BCD digits per operand (>=1), operand width 4*DIGITS
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   request, sampled only while idle or in the done cycle
//   a        in   minuend, packed BCD, digit 0 in bits [3:0]
//   b        in   subtrahend, packed BCD
//   bin      in   borrow-in
//   busy     out  high while digits are being processed
//   done     out  one-cycle pulse, diff/bout/invalid valid
//   diff     out  packed-BCD difference (tens complement when bout=1)
//   bout     out  borrow-out, set when a < b + bin
//   invalid  out  set if any latched digit of a or b is above 9

module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  bout,
    output logic                  invalid
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_q,   state_d;
    logic [4*DIGITS-1:0] a_q,       a_d;
    logic [4*DIGITS-1:0] b_q,       b_d;
    logic                borrow_q,  borrow_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic [4*DIGITS-1:0] diff_q,    diff_d;
    logic                bout_q,    bout_d;
    logic                invalid_q, invalid_d;

    logic [3:0] aDigit;
    logic [3:0] bDigit;
    logic [4:0] rawDiff;
    logic [3:0] digitOut;
    logic       digitBorrow;
    logic       digitInvalid;
    logic       lastDigit;

    // Select the current digit pair from the latched operands. A compare
    // loop keeps the mux free of variable-width index arithmetic.
    always_comb begin
        aDigit = 4'd0;
        bDigit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                aDigit = a_q[4*k +: 4];
                bDigit = b_q[4*k +: 4];
            end
        end
    end

    // One digit of subtraction. The 5-bit result is negative exactly when
    // bit 4 is set; adding 10 to the low nibble alone gives the same low
    // four bits as (t + 10), so the top bit never has to be carried along.
    always_comb begin
        rawDiff      = {1'b0, aDigit} - {1'b0, bDigit} - {4'd0, borrow_q};
        digitBorrow  = rawDiff[4];
        digitOut     = digitBorrow ? (rawDiff[3:0] + 4'd10) : rawDiff[3:0];
        digitInvalid = (aDigit > 4'd9) || (bDigit > 4'd9);
        lastDigit    = (idx_q == IDX_W'(DIGITS - 1));
    end

    // Next-state logic. Start is honoured in the done cycle as well as in
    // idle so operations can run back to back with no gap. diff and bout
    // are untouched on accept so the previous result stays visible.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        borrow_d  = borrow_q;
        idx_d     = idx_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        invalid_d = invalid_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    borrow_d  = bin;
                    idx_d     = '0;
                    invalid_d = 1'b0;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        diff_d[4*k +: 4] = digitOut;
                    end
                end
                borrow_d  = digitBorrow;
                invalid_d = invalid_q | digitInvalid;
                if (lastDigit) begin
                    bout_d  = digitBorrow;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything, aborting any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            borrow_q  <= 1'b0;
            idx_q     <= '0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            borrow_q  <= borrow_d;
            idx_q     <= idx_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign diff    = diff_q;
    assign bout    = bout_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor
//   Directed self-checking bench for bcd_serial_subtractor with DIGITS=4.
//   Each step drives an operation, waits (bounded) for done and compares
//   latency, diff, bout, invalid and busy against hand-computed values.

module tb_bcd_serial_subtractor;

    localparam int DIGITS  = 4;
    localparam int LATENCY = DIGITS + 1;
    localparam int BUDGET  = 20;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        invalid;

    int compareCount;
    int failCount;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .invalid (invalid)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, asserts, reports on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present an operation on a falling edge, let the rising edge accept it,
    // then scramble the operand inputs to show only latched copies matter.
    task automatic applyStimulus(input logic [15:0] aV, input logic [15:0] bV,
                                 input logic binV);
        start = 1'b1;
        a     = aV;
        b     = bV;
        bin   = binV;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = ~aV;
        b     = ~bV;
        bin   = ~binV;
    endtask

    // Called on the first falling edge after acceptance. Counts falling
    // edges until done, bounded, then checks the whole result.
    task automatic checkResult(input string tag, input logic [15:0] expDiff,
                               input logic expBout, input logic expInv);
        int cycles;
        cycles = 1;
        while (done !== 1'b1 && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(LATENCY));
        checkOutput({tag, "_diff"},    32'(diff),    32'(expDiff));
        checkOutput({tag, "_bout"},    32'(bout),    32'(expBout));
        checkOutput({tag, "_invalid"}, 32'(invalid), 32'(expInv));
        checkOutput({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        bin   = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_done",    32'(done),    32'd0);
        checkOutput("rst_diff",    32'(diff),    32'd0);
        checkOutput("rst_bout",    32'(bout),    32'd0);
        checkOutput("rst_invalid", 32'(invalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic subtraction, busy during RUN.
        applyStimulus(16'h0042, 16'h0017, 1'b0);
        checkOutput("t1_busy_run", 32'(busy), 32'd1);
        checkResult("t1", 16'h0025, 1'b0, 1'b0);

        // Result held in idle afterwards.
        @(negedge clk);
        checkOutput("t1_idle_done", 32'(done), 32'd0);
        checkOutput("t1_idle_diff", 32'(diff), 32'h0025);

        // Borrow across all digits, then borrow absorbed by the top digit.
        applyStimulus(16'h0000, 16'h0001, 1'b0);
        checkResult("t2a", 16'h9999, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(16'h1000, 16'h0001, 1'b0);
        checkResult("t2b", 16'h0999, 1'b0, 1'b0);
        @(negedge clk);

        // Borrow-in at the extreme operand values.
        applyStimulus(16'h9999, 16'h9999, 1'b1);
        checkResult("t3a", 16'h9999, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(16'h9999, 16'h9999, 1'b0);
        checkResult("t3b", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        // Mixed-digit case.
        applyStimulus(16'h1234, 16'h0567, 1'b0);
        checkResult("t3c", 16'h0667, 1'b0, 1'b0);
        @(negedge clk);

        // Invalid digits pass through the arithmetic unchanged and flag.
        applyStimulus(16'h00A0, 16'h0000, 1'b0);
        checkResult("t4a", 16'h00A0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(16'h0000, 16'h000F, 1'b0);
        checkResult("t4b", 16'h999B, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(16'h0005, 16'h0003, 1'b0);
        checkResult("t4c", 16'h0002, 1'b0, 1'b0);
        @(negedge clk);

        // Start pulsed during RUN with other operands is ignored.
        applyStimulus(16'h0042, 16'h0017, 1'b0);
        start = 1'b1;
        a     = 16'h0888;
        b     = 16'h0111;
        bin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int cycles;
            cycles = 2;
            while (done !== 1'b1 && cycles < BUDGET) begin
                @(negedge clk);
                cycles++;
            end
            checkOutput("t5a_latency", 32'(cycles), 32'(LATENCY));
            checkOutput("t5a_diff",    32'(diff),   32'h0025);
            checkOutput("t5a_bout",    32'(bout),   32'd0);
        end
        @(negedge clk);
        checkOutput("t5a_no_restart", 32'(busy), 32'd0);

        // Back-to-back: start held in the done cycle is accepted.
        applyStimulus(16'h5000, 16'h0001, 1'b0);
        checkResult("t5b_first", 16'h4999, 1'b0, 1'b0);
        applyStimulus(16'h0100, 16'h0200, 1'b0);
        checkResult("t5b_second", 16'h9900, 1'b1, 1'b0);
        @(negedge clk);

        // Reset two cycles into RUN aborts with no done pulse.
        applyStimulus(16'h0042, 16'h0017, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t6_busy",    32'(busy),    32'd0);
        checkOutput("t6_done",    32'(done),    32'd0);
        checkOutput("t6_diff",    32'(diff),    32'd0);
        checkOutput("t6_bout",    32'(bout),    32'd0);
        checkOutput("t6_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int doneSeen;
            doneSeen = 0;
            for (int i = 0; i < LATENCY + 1; i++) begin
                @(negedge clk);
                if (done === 1'b1) doneSeen++;
            end
            checkOutput("t6_no_done", 32'(doneSeen), 32'd0);
        end

        // Fresh operation after the abort.
        applyStimulus(16'h0777, 16'h0123, 1'b0);
        checkResult("t6_fresh", 16'h0654, 1'b0, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
